// File: rtl/servo_pwm_pkg.sv
// Shared constants, slew state encoding and counter sizing for the servo PWM block.
package servo_pkg;

  localparam int POS_W_DEF        = 8;
  localparam int PERIOD_TICKS_DEF = 20000;
  localparam int MIN_PULSE_DEF    = 1000;
  localparam int SCALE_DEF        = 4;
  localparam int STEP_DEF         = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } slew_state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/servo_pwm_if.sv
// Position request handshake: master offers a target, slave accepts when ready.
interface servo_pwm_if
  import servo_pkg::*;
#(
  parameter int POS_W = POS_W_DEF
) ();

  logic             req_valid;
  logic [POS_W-1:0] req_pos;
  logic             req_ready;

  modport master (output req_valid, output req_pos, input req_ready);
  modport slave  (input req_valid, input req_pos, output req_ready);

endinterface

// File: rtl/servo_pwm_frame_cnt.sv
// Tick-enabled modulo-PERIOD_TICKS frame counter; wrap flags the last tick of a frame.
module pwm_frame_cnt
  import servo_pkg::*;
#(
  parameter int  PERIOD_TICKS = PERIOD_TICKS_DEF,
  localparam int CW           = cnt_width(PERIOD_TICKS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  assign wrap = tick && (cnt == CW'(PERIOD_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/servo_pwm.sv
// Servo PWM generator: accepts target positions, slews cur_pos at frame boundaries,
// and drives a registered pulse of MIN_PULSE + cur_pos*SCALE ticks each frame.
//
//   state | meaning
//   IDLE  | cur_pos == target, busy low
//   SLEW  | cur_pos still walking toward target, busy high
module servo_pwm
  import servo_pkg::*;
#(
  parameter int PERIOD_TICKS = PERIOD_TICKS_DEF,
  parameter int MIN_PULSE    = MIN_PULSE_DEF,
  parameter int SCALE        = SCALE_DEF,
  parameter int POS_W        = POS_W_DEF,
  parameter int STEP         = STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  servo_pwm_if.slave       req,
  output logic             pwm,
  output logic [POS_W-1:0] cur_pos,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = cnt_width(PERIOD_TICKS);
  localparam logic [POS_W:0] STEP_V = (POS_W + 1)'(STEP);

  if (MIN_PULSE + (2 ** POS_W - 1) * SCALE >= PERIOD_TICKS) begin : g_bad_timing
    $error("servo_pwm: widest pulse does not fit inside one frame");
  end
  if (STEP < 1 || STEP > 2 ** POS_W - 1) begin : g_bad_step
    $error("servo_pwm: STEP out of range");
  end

  logic [CW-1:0]    cnt;
  logic             wrap;
  logic [CW-1:0]    pulse_w;
  logic             pend_vld;
  logic [POS_W-1:0] pend_pos;
  logic [POS_W-1:0] target;
  slew_state_t      state;

  logic             accept;
  logic [POS_W-1:0] target_nxt;
  logic [POS_W-1:0] cur_nxt;
  logic [POS_W:0]   diff;
  logic [POS_W:0]   sum;
  logic [CW-1:0]    pulse_nxt;

  pwm_frame_cnt #(.PERIOD_TICKS(PERIOD_TICKS)) u_frame_cnt (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .cnt  (cnt),
    .wrap (wrap)
  );

  assign req.req_ready = !pend_vld;
  assign accept        = req.req_valid && !pend_vld;
  assign busy          = (state == SLEW);

  // cur_pos chases the target held before this wrap; a freshly loaded target waits a frame.
  always_comb begin
    target_nxt = pend_vld ? pend_pos : target;
    diff       = '0;
    sum        = {1'b0, cur_pos};
    cur_nxt    = cur_pos;
    if (target > cur_pos) begin
      diff    = {1'b0, target} - {1'b0, cur_pos};
      sum     = {1'b0, cur_pos} + ((diff < STEP_V) ? diff : STEP_V);
      cur_nxt = sum[POS_W] ? '1 : sum[POS_W-1:0];
    end else if (target < cur_pos) begin
      diff    = {1'b0, cur_pos} - {1'b0, target};
      sum     = {1'b0, cur_pos} - ((diff < STEP_V) ? diff : STEP_V);
      cur_nxt = sum[POS_W] ? '0 : sum[POS_W-1:0];
    end
    pulse_nxt = CW'(MIN_PULSE) + CW'(cur_nxt) * CW'(SCALE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pend_vld    <= 1'b0;
      pend_pos    <= '0;
      target      <= '0;
      cur_pos     <= '0;
      pulse_w     <= CW'(MIN_PULSE);
      pwm         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pwm         <= (cnt < pulse_w);
      frame_start <= wrap;

      if (wrap) begin
        target   <= target_nxt;
        cur_pos  <= cur_nxt;
        pulse_w  <= pulse_nxt;
        pend_vld <= 1'b0;
      end
      // A request taken on the wrap edge must survive the pending clear above.
      if (accept) begin
        pend_vld <= 1'b1;
        pend_pos <= req.req_pos;
      end

      case (state)
        IDLE: if (wrap && cur_nxt != target_nxt) state <= SLEW;
        SLEW: if (wrap && cur_nxt == target_nxt) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/servo_pwm.md
# servo_pwm

Servo pulse generator sitting directly downstream of the clock divider. Consumes a one-cycle `tick` strobe (1 µs nominal) produced from the divider and generates a standard hobby-servo PWM frame. Commanded positions are accepted over a valid/ready handshake and applied at frame boundaries with a per-frame slew limit, so the mechanics never see a step larger than `STEP`.

## Interface
- `PERIOD_TICKS`, 20000: ticks per PWM frame (20 ms at 1 µs tick).
- `MIN_PULSE`, 1000: pulse width in ticks for position 0.
- `SCALE`, 4: ticks added per position LSB; pulse = `MIN_PULSE + pos*SCALE`.
- `POS_W`, 8: position width.
- `STEP`, 4: maximum change of the current position per frame, 1..2^POS_W-1.
- Legal only if `MIN_PULSE + (2^POS_W-1)*SCALE < PERIOD_TICKS`; elaboration error otherwise.

- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: time-base strobe from the divider stage; the frame counter advances only when high.
- `req_valid` in 1: new target position offered.
- `req_pos` in POS_W: requested target position.
- `req_ready` out 1: block can accept a request.
- `pwm` out 1: servo drive output, registered.
- `cur_pos` out POS_W: position currently being driven.
- `frame_start` out 1: one-cycle pulse at each frame wrap.
- `busy` out 1: `cur_pos != target`.

## Operation
- Registers: `cnt` (frame counter, width clog2(PERIOD_TICKS)), `pend_vld`/`pend_pos`, `target`, `cur_pos`, `pulse_w`, `pwm`.
- Reset values: `cnt`=0, `pend_vld`=0, `pend_pos`=0, `target`=0, `cur_pos`=0, `pulse_w`=MIN_PULSE, `pwm`=0, `frame_start`=0, `req_ready`=1, `busy`=0.
- Handshake: `req_ready = !pend_vld`. Transfer when `req_valid && req_ready`; `pend_pos <= req_pos`, `pend_vld <= 1`. `req_pos` is ignored while `req_ready`=0. At most one request per frame.
- Frame counter: on `tick`, `cnt` increments; at `cnt == PERIOD_TICKS-1` it wraps to 0 (the wrap event). No `tick` means `cnt` holds.
- At the wrap event, in the same cycle:
  - If `pend_vld`, then `target <= pend_pos` and `pend_vld <= 0`.
  - `cur_pos` moves toward the *old* target (the value before this update): `+min(STEP, target-cur_pos)` if above, or `-min(STEP, cur_pos-target)` if below. Arithmetic is in POS_W+1 bits, with no wrap past 0 or 2^POS_W-1.
  - `pulse_w <= MIN_PULSE + next_cur_pos*SCALE`.
- Slew FSM: IDLE (`cur_pos==target`, `busy`=0) and SLEW (`busy`=1). IDLE goes to SLEW when `target` changes to a different value. SLEW goes to IDLE at the wrap that makes `cur_pos==target`.
- `pwm <= (cnt < pulse_w)`, updated every cycle.
- A request accepted in the same cycle as a wrap event is not applied at that wrap. It lands in `pending` and is applied at the next wrap.
- A `tick` asserted during `rst` is ignored.
- Reset mid-frame returns everything to reset values on the next edge. `pwm` drops to 0 and the frame restarts at `cnt`=0.

## Timing
- `pwm` has a 1-cycle latency from `cnt`. After reset, `pwm` rises the cycle after the first clock with `rst`=0, and stays high for MIN_PULSE ticks.
- `frame_start` is registered and high for exactly one cycle, the cycle after the wrap event.
- `req_ready` deasserts the cycle after acceptance and reasserts the cycle after the wrap that consumes `pending`.
- A new target first affects `cur_pos` at the wrap after it is loaded. That is 1 to 2 frames after acceptance.
- Full-scale move 0 to 255 with STEP=4 takes 64 frames.

## Structure
- Package `servo_pkg`:
  - the POS_W default;
  - the default timing constants (PERIOD_TICKS, MIN_PULSE, SCALE, STEP);
  - the state enum {IDLE, SLEW};
  - a clog2-based counter-width function.
- One sub-module, `pwm_frame_cnt`: tick-enabled modulo-PERIOD_TICKS counter with a `wrap` output. Slew, handshake and compare logic stay in `servo_pwm`.

## Test plan
- Reset with `tick` held high every cycle:
  - `pwm` high for exactly 1000 cycles, then low for 19000;
  - `frame_start` pulses every 20000 cycles;
  - `cur_pos`=0.
- Request pos=10 mid-frame 0:
  - `req_ready` drops for one frame;
  - `cur_pos` steps to 4 at wrap 2, 8 at wrap 3, 10 at wrap 4, then `busy`=0;
  - final pulse width 1040 ticks.
- Request pos=200 exactly on a wrap cycle: `target` unchanged at that wrap, loaded at the next one; second request during `req_ready`=0 is dropped.
- From `cur_pos`=10, request pos=0: 10→6→2→0, no underflow.
- `tick` asserted every 3rd cycle: frame length 60000 cycles, pulse 3000 cycles at pos 0.
- Assert `rst` for one cycle mid-pulse at pos 100: next cycle `pwm`=0, `cur_pos`=0, `req_ready`=1, `busy`=0, new frame starts.
